// File: rtl/rvfi_trace_sink.sv
// rvfi_trace_sink: captures RVFI retirements into a record FIFO, checks trace consistency, streams records as bytes.
// Optional macro RVFI_TRACE_SINK_MEM_EN adds memory fields (24-byte records) and o_err_mem.
module rvfi_trace_sink #(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              rvfi_valid,
    input  logic [63:0]       rvfi_order,
    input  logic [31:0]       rvfi_insn,
    input  logic              rvfi_trap,
    input  logic              rvfi_halt,
    input  logic              rvfi_intr,
    input  logic [4:0]        rvfi_rd_addr,
    input  logic [31:0]       rvfi_rd_wdata,
    input  logic [31:0]       rvfi_pc_rdata,
`ifdef RVFI_TRACE_SINK_MEM_EN
    input  logic [31:0]       rvfi_mem_addr,
    input  logic [3:0]        rvfi_mem_rmask,
    input  logic [3:0]        rvfi_mem_wmask,
    output logic              o_err_mem,
`endif
    input  logic              i_clear_err,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_err_order,
    output logic              o_err_x0,
    output logic              o_overflow,
    output logic [DROP_W-1:0] o_drop_count
);
`ifdef RVFI_TRACE_SINK_MEM_EN
    localparam int NB = 24;
`else
    localparam int NB = 16;
`endif
    localparam int RW = NB * 8;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = 5;

    logic [RW-1:0]  mem [DEPTH];
    logic [127:0]   base;
    logic [RW-1:0]  rec, head;
    logic [AW-1:0]  wr_ptr, rd_ptr, rd_ptr_n;
    logic [CW-1:0]  count, count_n, left;
    logic [IW-1:0]  idx, idx_n;
    logic [63:0]    exp_order;
    logic           xfer, pop, push, drop;

    assign base = {rvfi_order[15:0], 5'b0, rvfi_intr, rvfi_halt, rvfi_trap, 3'b0, rvfi_rd_addr,
                   rvfi_rd_wdata, rvfi_insn, rvfi_pc_rdata};
`ifdef RVFI_TRACE_SINK_MEM_EN
    assign rec = {24'b0, rvfi_mem_wmask, rvfi_mem_rmask, rvfi_mem_addr, base};
`else
    assign rec = base;
`endif

    // Head bypasses the memory when the incoming record is the only one left after this cycle's pop.
    always_comb begin
        xfer     = o_tx_valid && i_tx_ready;
        pop      = xfer && idx == IW'(NB - 1);
        push     = rvfi_valid && (count != CW'(DEPTH) || pop);
        drop     = rvfi_valid && !push;
        left     = count - CW'(pop);
        count_n  = left + CW'(push);
        rd_ptr_n = rd_ptr + AW'(pop);
        idx_n    = pop ? '0 : idx + IW'(xfer);
        head     = left == '0 ? rec : mem[rd_ptr_n];
    end

    always_ff @(posedge i_clk)
        if (push) mem[wr_ptr] <= rec;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            idx          <= '0;
            exp_order    <= '0;
            o_tx_valid   <= 1'b0;
            o_tx_data    <= '0;
            o_err_order  <= 1'b0;
            o_err_x0     <= 1'b0;
            o_overflow   <= 1'b0;
            o_drop_count <= '0;
        end else begin
            wr_ptr       <= wr_ptr + AW'(push);
            rd_ptr       <= rd_ptr_n;
            count        <= count_n;
            idx          <= idx_n;
            o_tx_valid   <= count_n != '0;
            if (count_n != '0) o_tx_data <= head[{idx_n, 3'b0} +: 8];
            if (rvfi_valid) exp_order <= rvfi_order + 64'd1;
            o_err_order  <= (rvfi_valid && rvfi_order != exp_order) || (o_err_order && !i_clear_err);
            o_err_x0     <= (rvfi_valid && rvfi_rd_addr == '0 && rvfi_rd_wdata != '0) || (o_err_x0 && !i_clear_err);
            o_overflow   <= drop || (o_overflow && !i_clear_err);
            o_drop_count <= i_clear_err ? '0 : o_drop_count + DROP_W'(drop && o_drop_count != '1);
        end
    end

`ifdef RVFI_TRACE_SINK_MEM_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) o_err_mem <= 1'b0;
        else o_err_mem <= (rvfi_valid && rvfi_mem_rmask != '0 && rvfi_mem_wmask != '0) || (o_err_mem && !i_clear_err);
    end
`endif
endmodule

// File: doc/rvfi_trace_sink.md
Name: rvfi_trace_sink

Overview:
- Consumer end of the core's RVFI retirement interface: captures each retired instruction and checks trace consistency.
- Packs each retirement into a fixed record, buffers it in a FIFO and drains it as a byte stream with valid/ready handshake, for a debug UART or a logic-analyser bridge.
- Sits beside the cpu top; connects directly to its rvfi_* outputs.

Parameters:
- DEPTH, 16, FIFO depth in records; power of two, minimum 2.
- DROP_W, 16, width of the saturating dropped-record counter.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  asynchronous active-high reset.
- rvfi_valid  input  1  retirement strobe.
- rvfi_order  input  64  retirement index.
- rvfi_insn  input  32  retired instruction word.
- rvfi_trap  input  1  trap flag.
- rvfi_halt  input  1  halt flag.
- rvfi_intr  input  1  interrupt flag.
- rvfi_rd_addr  input  5  destination register.
- rvfi_rd_wdata  input  32  destination write data.
- rvfi_pc_rdata  input  32  PC of the retired instruction.
- i_clear_err  input  1  synchronous clear of sticky error flags and drop count.
- o_tx_data  output  8  stream byte.
- o_tx_valid  output  1  stream byte valid.
- i_tx_ready  input  1  stream sink ready.
- o_err_order  output  1  sticky: rvfi_order discontinuity.
- o_err_x0  output  1  sticky: write of a nonzero value to x0.
- o_overflow  output  1  sticky: record dropped because FIFO full.
- o_drop_count  output  DROP_W  saturating count of dropped records.

Behaviour:
- Reset (async, i_rst=1): FIFO empty, byte index 0, expected order 0, o_tx_valid=0, o_tx_data=0, all sticky flags 0, o_drop_count=0. o_tx_valid deasserts immediately, mid-record included; a partially sent record is discarded.
- Record, 16 bytes, sent little-endian within each word:
  - word0 = pc_rdata
  - word1 = insn
  - word2 = rd_wdata
  - word3 = {order[15:0], 5'b0, intr, halt, trap, 3'b0, rd_addr}
  - Byte 0 is pc_rdata[7:0]; byte 15 is order[15:8].
- Capture: on each clock with rvfi_valid=1, the record is formed from same-cycle inputs and pushed at that edge. Earliest o_tx_valid is the following cycle (1-cycle latency from an empty FIFO).
- Order checker: runs on every valid retirement, including dropped ones.
  - If rvfi_order != expected, set o_err_order.
  - expected <= rvfi_order + 1 (resynchronises, so one gap gives one error).
- x0 checker: rvfi_valid && rd_addr==0 && rd_wdata!=0 sets o_err_x0.
- Stream rules:
  - o_tx_data/o_tx_valid are registered and stay stable while o_tx_valid && !i_tx_ready.
  - A byte is transferred when both are high; the byte index then advances 0..15.
  - The head record pops on the transfer of byte 15; the next record's byte 0 is presented the next cycle with no bubble if the FIFO is non-empty.
- Full: a push while the FIFO is full is dropped unless a pop occurs in the same cycle; a simultaneous pop and push when full is accepted. A dropped push sets o_overflow and increments o_drop_count, saturating at all-ones.
- Empty: o_tx_valid=0, and o_tx_data holds its last value.
- Occupancy counter is log2(DEPTH)+1 bits; read and write pointers wrap modulo DEPTH.
- i_clear_err=1 clears o_err_order, o_err_x0, o_overflow and o_drop_count at the edge. If an error event occurs in the same cycle, the event wins and the flag is set; the counter is cleared to 0 and does not increment that cycle.
- The RVFI inputs have no backpressure; the sink never stalls the core.

Optional Feature:
- Macro RVFI_TRACE_SINK_MEM_EN.
- Defined:
  - Adds inputs rvfi_mem_addr (32), rvfi_mem_rmask (4) and rvfi_mem_wmask (4).
  - Record grows to 24 bytes: word4 = mem_addr; word5 = {24'b0, wmask, rmask}.
  - Byte index runs 0..23 and the pop happens on byte 23.
  - Adds the check: rmask and wmask both nonzero sets o_err_order's sibling flag o_err_mem (new output, sticky, same reset/clear rules).
- Undefined: those ports and o_err_mem do not exist; record is 16 bytes.

Test Plan:
- Single retirement, tx_ready=1: pc=0x10000000, insn=0x00500093, rd=1, wdata=5, order=0. Expect o_tx_valid the next cycle, then 16 consecutive bytes 00 00 00 10 93 00 50 00 05 00 00 00 01 00 00 00, and no error flags set.
- Backpressure: hold i_tx_ready=0 for 5 cycles mid-record at byte 6. Expect o_tx_data constant at 0x50 and o_tx_valid=1 throughout; the stream resumes with byte 7.
- Order gap: retire orders 0, 1, 3, 4. Expect o_err_order set after order 3, and no further error on 4; then i_clear_err=1 gives o_err_order=0.
- Overflow: DEPTH=16, tx_ready=0, 18 back-to-back retirements. Expect o_overflow=1, o_drop_count=2, and exactly 16 records drained once ready=1.
- x0 write: rd_addr=0, wdata=0xDEADBEEF. Expect o_err_x0=1; with rd_addr=0 and wdata=0 the flag stays 0.
- Async reset mid-record at byte 9: o_tx_valid=0 immediately. After release, expect empty FIFO and flags 0; the next retirement with order=0 gives no order error.
